// File: rtl/adder32_0_pkg.sv
// Shared types and constants for the approximate 11-in/6-out adder partition
// and its QoR error monitor.
package adder32_0_pkg;

   localparam int unsigned OPW  = 5;
   localparam int unsigned SUMW = OPW + 1;

   // Partition pin mapping: pi00 = cin, pi01..pi05 = a MSB first,
   // pi06..pi10 = b MSB first, po0..po5 = sum MSB first.
   localparam int unsigned NUM_PI     = 11;
   localparam int unsigned NUM_PO     = 6;
   localparam int unsigned PI_CIN     = 0;
   localparam int unsigned PI_A_FIRST = 1;
   localparam int unsigned PI_B_FIRST = 6;
   localparam int unsigned PO_FIRST   = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [OPW-1:0]  a;
      logic [OPW-1:0]  b;
      logic            cin;
      logic [SUMW-1:0] approx;
   } sample_t;

   // Unpack raw partition pins into a sample (used by the offline checker).
   function automatic sample_t pins_to_sample(input logic [NUM_PI-1:0] pi,
                                              input logic [NUM_PO-1:0] po);
      sample_t s;
      s.cin    = pi[PI_CIN];
      s.a      = {pi[PI_A_FIRST], pi[PI_A_FIRST+1], pi[PI_A_FIRST+2],
                  pi[PI_A_FIRST+3], pi[PI_A_FIRST+4]};
      s.b      = {pi[PI_B_FIRST], pi[PI_B_FIRST+1], pi[PI_B_FIRST+2],
                  pi[PI_B_FIRST+3], pi[PI_B_FIRST+4]};
      s.approx = {po[PO_FIRST], po[PO_FIRST+1], po[PO_FIRST+2],
                  po[PO_FIRST+3], po[PO_FIRST+4], po[PO_FIRST+5]};
      return s;
   endfunction

endpackage

// File: rtl/adder32_0_err_calc.sv
// Exact sum and absolute error of an approximate sum; purely combinational.
module adder32_0_err_calc
   import adder32_0_pkg::*;
(
   input  logic [OPW-1:0]  a_i,
   input  logic [OPW-1:0]  b_i,
   input  logic            cin_i,
   input  logic [SUMW-1:0] approx_i,
   output logic [SUMW-1:0] exact_c_o,
   output logic [SUMW-1:0] diff_c_o
);

   logic [SUMW-1:0] exact;

   // SUMW bits hold the largest a + b + cin, so no carry is lost.
   assign exact     = SUMW'(a_i) + SUMW'(b_i) + SUMW'(cin_i);
   assign exact_c_o = exact;
   assign diff_c_o  = (approx_i >= exact) ? (approx_i - exact) : (exact - approx_i);

endmodule

// File: rtl/adder32_0_err_monitor.sv
// QoR monitor: pipelines (a, b, cin, approx) samples through an exact-sum
// check and accumulates error count, summed and maximum absolute error per run.
module adder32_0_err_monitor
   import adder32_0_pkg::*;
#(
   parameter int unsigned N_SAMPLES = 1024,
   parameter int unsigned CNT_W     = 17,
   parameter int unsigned ACC_W     = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   in_a,
   input  logic [OPW-1:0]   in_b,
   input  logic             in_cin,
   input  logic [SUMW-1:0]  approx_sum,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [ACC_W-1:0] sum_abs_err,
   output logic [SUMW-1:0]  max_abs_err
);

   state_e           state_q, state_d;
   logic             in_ready_q, busy_q, done_q;
   logic [CNT_W-1:0] acc_cnt_q;

   logic             s1_valid_q;
   sample_t          s1_q;
   logic             s2_valid_q;
   logic             s2_err_q;
   logic [SUMW-1:0]  s2_diff_q;

   logic [CNT_W-1:0] err_q;
   logic [ACC_W-1:0] sum_q;
   logic [SUMW-1:0]  max_q;

   logic             hs_c, last_c, start_ok_c;
   logic [SUMW-1:0]  exact_c, diff_c;
   logic [ACC_W:0]   sum_ext_c;
   logic [ACC_W-1:0] sum_sat_c;

   assign hs_c       = in_valid && in_ready_q;
   assign last_c     = hs_c && (acc_cnt_q == CNT_W'(N_SAMPLES - 1));
   assign start_ok_c = start && ((state_q == IDLE) || (state_q == DONE));

   adder32_0_err_calc u_err_calc (
      .a_i       (s1_q.a),
      .b_i       (s1_q.b),
      .cin_i     (s1_q.cin),
      .approx_i  (s1_q.approx),
      .exact_c_o (exact_c),
      .diff_c_o  (diff_c)
   );

   // DRAIN leaves once S1 is empty: the sample in S2 lands in the stats on
   // the same edge that enters DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)       state_d = RUN;
         RUN:     if (last_c)      state_d = DRAIN;
         DRAIN:   if (!s1_valid_q) state_d = DONE;
         DONE:    if (start)       state_d = RUN;
         default:                  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         acc_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d == RUN);
         busy_q     <= (state_d == RUN) || (state_d == DRAIN);
         done_q     <= (state_d == DONE);
         if (start_ok_c)
            acc_cnt_q <= '0;
         else if (hs_c)
            acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      end
   end

   // Saturating accumulate; once all-ones it stays there until restart.
   assign sum_ext_c = {1'b0, sum_q} + (ACC_W + 1)'(s2_diff_q);
   assign sum_sat_c = sum_ext_c[ACC_W] ? '1 : sum_ext_c[ACC_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         s2_err_q   <= 1'b0;
         s2_diff_q  <= '0;
         err_q      <= '0;
         sum_q      <= '0;
         max_q      <= '0;
      end else begin
         s1_valid_q <= hs_c;
         if (hs_c)
            s1_q <= '{a: in_a, b: in_b, cin: in_cin, approx: approx_sum};
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_err_q  <= (s1_q.approx != exact_c);
            s2_diff_q <= diff_c;
         end
         if (start_ok_c) begin
            err_q <= '0;
            sum_q <= '0;
            max_q <= '0;
         end else if (s2_valid_q) begin
            err_q <= err_q + CNT_W'(s2_err_q);
            sum_q <= sum_sat_c;
            if (s2_diff_q > max_q)
               max_q <= s2_diff_q;
         end
      end
   end

   assign in_ready    = in_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_count   = err_q;
   assign sum_abs_err = sum_q;
   assign max_abs_err = max_q;

endmodule

// File: tb/tb_adder32_0_err_monitor.sv
// Directed bench for adder32_0_err_monitor: three instances (long run, tiny
// saturating accumulator, exhaustive sweep) share one stimulus bus.
module tb_adder32_0_err_monitor;
   import adder32_0_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]      start_v;
   logic            in_valid;
   logic [OPW-1:0]  in_a, in_b;
   logic            in_cin;
   logic [SUMW-1:0] approx;

   logic [2:0]      rdy, bsy, dn;
   logic [16:0]     err_a, err_b, err_c;
   logic [23:0]     sum_a, sum_c;
   logic [5:0]      sum_b;
   logic [5:0]      max_a, max_b, max_c;

   adder32_0_err_monitor #(.N_SAMPLES(1024), .CNT_W(17), .ACC_W(24)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .approx_sum(approx),
      .busy(bsy[0]), .done(dn[0]), .err_count(err_a), .sum_abs_err(sum_a), .max_abs_err(max_a));

   adder32_0_err_monitor #(.N_SAMPLES(2), .CNT_W(17), .ACC_W(6)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .approx_sum(approx),
      .busy(bsy[1]), .done(dn[1]), .err_count(err_b), .sum_abs_err(sum_b), .max_abs_err(max_b));

   adder32_0_err_monitor #(.N_SAMPLES(2048), .CNT_W(17), .ACC_W(24)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .approx_sum(approx),
      .busy(bsy[2]), .done(dn[2]), .err_count(err_c), .sum_abs_err(sum_c), .max_abs_err(max_c));

   int errors = 0;
   int checks = 0;
   int sel = 0;

   logic [63:0] err_s, sum_s, max_s;
   always_comb begin
      case (sel)
         1:       begin err_s = 64'(err_b); sum_s = 64'(sum_b); max_s = 64'(max_b); end
         2:       begin err_s = 64'(err_c); sum_s = 64'(sum_c); max_s = 64'(max_c); end
         default: begin err_s = 64'(err_a); sum_s = 64'(sum_a); max_s = 64'(max_a); end
      endcase
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] exact_sum(input logic [4:0] a, input logic [4:0] b, input logic c);
      return 6'(a) + 6'(b) + 6'(c);
   endfunction

   // Golden k=4 partition: lower 4 bits ORed, carry into the top guessed from bit 3.
   function automatic logic [5:0] approx_k4(input logic [4:0] a, input logic [4:0] b);
      logic [1:0] hi;
      hi = 2'(a[4]) + 2'(b[4]) + 2'(a[3] & b[3]);
      return {hi, a[3:0] | b[3:0]};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input int s);
      start_v = 3'(1 << s);
      tick(1);
      start_v = '0;
   endtask

   task automatic send(input logic [4:0] a, input logic [4:0] b, input logic c, input logic [5:0] ap);
      in_a = a; in_b = b; in_cin = c; approx = ap;
      in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!dn[sel] && n < 20) begin
         tick(1);
         n++;
      end
      check(tag, 64'(dn[sel]), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [4:0] a, b;
      logic       c;
      logic [5:0] ex, ap, d;
      int         e_err, e_sum, e_max;

      start_v = '0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; approx = '0;
      tick(3);
      @(negedge clk) rst_n = 1'b1;
      tick(1);

      // Reset state
      check("rst_ready", 64'(rdy[0]), 0);
      check("rst_busy",  64'(bsy[0]), 0);
      check("rst_done",  64'(dn[0]),  0);
      check("rst_err",   err_s, 0);
      check("rst_sum",   sum_s, 0);
      check("rst_max",   max_s, 0);

      // Reset in the middle of a run with samples in flight
      pulse_start(0);
      check("run_ready", 64'(rdy[0]), 1);
      check("run_busy",  64'(bsy[0]), 1);
      for (int i = 0; i < 10; i++) send(5'd1, 5'd1, 1'b0, 6'd3);
      check("inflight_err", err_s, 8);
      check("inflight_sum", sum_s, 8);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 64'(rdy[0]), 0);
      check("mid_rst_busy",  64'(bsy[0]), 0);
      check("mid_rst_done",  64'(dn[0]),  0);
      check("mid_rst_err",   err_s, 0);
      check("mid_rst_sum",   sum_s, 0);
      check("mid_rst_max",   max_s, 0);
      @(negedge clk) rst_n = 1'b1;
      tick(1);

      // Clean run: approx always exact
      pulse_start(0);
      for (int i = 0; i < 1024; i++) begin
         a = 5'(i); b = 5'(i >> 5); c = 1'(i ^ (i >> 5));
         send(a, b, c, exact_sum(a, b, c));
      end
      wait_done("clean_done");
      check("clean_err",   err_s, 0);
      check("clean_sum",   sum_s, 0);
      check("clean_max",   max_s, 0);
      check("clean_busy",  64'(bsy[0]), 0);
      check("clean_ready", 64'(rdy[0]), 0);

      // in_valid while DONE must be ignored
      in_a = 5'd7; in_b = 5'd7; in_cin = 1'b0; approx = 6'd0; in_valid = 1'b1;
      tick(3);
      in_valid = 1'b0;
      tick(2);
      check("done_ignore_err", err_s, 0);
      check("done_hold",       64'(dn[0]), 1);

      // Bubble plus ignored mid-run start; last sample is the worst case
      pulse_start(0);
      send(5'd3, 5'd4, 1'b1, 6'd10);
      start_v = 3'b001;
      tick(1);
      start_v = '0;
      for (int i = 0; i < 1022; i++) begin
         a = 5'(i * 7); b = 5'(i >> 2); c = 1'(i);
         send(a, b, c, exact_sum(a, b, c));
      end
      send(5'd31, 5'd31, 1'b1, 6'd0);
      check("last_ready_drop", 64'(rdy[0]), 0);
      check("last_busy",       64'(bsy[0]), 1);
      check("done_t1",         64'(dn[0]),  0);
      tick(1);
      check("done_t2",         64'(dn[0]),  0);
      tick(1);
      check("done_t3",         64'(dn[0]),  1);
      check("toggle_err",      err_s, 2);
      check("toggle_sum",      sum_s, 65);
      check("toggle_max",      max_s, 63);

      // Saturating accumulator (ACC_W = 6), then restart clears saturation
      sel = 1;
      pulse_start(1);
      send(5'd31, 5'd31, 1'b1, 6'd0);
      send(5'd31, 5'd31, 1'b1, 6'd0);
      wait_done("sat_done");
      check("sat_err", err_s, 2);
      check("sat_sum", sum_s, 63);
      check("sat_max", max_s, 63);
      pulse_start(1);
      send(5'd3, 5'd4, 1'b1, 6'd10);
      send(5'd0, 5'd0, 1'b0, 6'd0);
      wait_done("small_done");
      check("small_err", err_s, 1);
      check("small_sum", sum_s, 2);
      check("small_max", max_s, 2);

      // Exhaustive 2^11 sweep against the k=4 partition model
      sel = 2;
      e_err = 0; e_sum = 0; e_max = 0;
      pulse_start(2);
      for (int ci = 0; ci < 2; ci++) begin
         for (int ai = 0; ai < 32; ai++) begin
            for (int bi = 0; bi < 32; bi++) begin
               a = 5'(ai); b = 5'(bi); c = 1'(ci);
               ex = exact_sum(a, b, c);
               ap = approx_k4(a, b);
               d  = (ap > ex) ? ap - ex : ex - ap;
               if (d != 0) e_err++;
               e_sum += int'(d);
               if (int'(d) > e_max) e_max = int'(d);
               send(a, b, c, ap);
            end
         end
      end
      wait_done("sweep_done");
      check("sweep_err", err_s, 64'(e_err));
      check("sweep_sum", sum_s, 64'(e_sum));
      check("sweep_max", max_s, 64'(e_max));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
